// File: rtl/step_pacer.sv
// Step pacer: debounced manual step key plus an auto-stepping prescaler with
// pause/resume, feeding a one-cycle clock-enable strobe to a downstream register.

// Per-key synchronizer and debouncer; press is a one-cycle pulse on a debounced 1->0.
module step_pacer_debounce #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic key,
  output logic press
);
  localparam int CW = $clog2(DB_CYCLES);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values and the synchronizer chain really is two stages.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
        // This edge is the one where the count would reach DB_CYCLES.
        level <= sync2;
        cnt   <= '0;
        press <= ~sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

module step_pacer #(
  parameter int TICK_DIV  = 50000000,
  parameter int DB_CYCLES = 1000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_step,
  input  logic       key_mode,
  output logic       step,
  output logic [1:0] mode,
  output logic [7:0] step_count
);
  localparam int PW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    MANUAL = 2'b00,
    AUTO   = 2'b01,
    HOLD   = 2'b10
  } mode_t;

  mode_t         state;
  mode_t         state_next;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_next;
  logic          step_next;
  logic          wrap;
  logic          step_ev;
  logic          mode_ev;

  step_pacer_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_step (
    .clock (clock),
    .reset (reset),
    .key   (key_step),
    .press (step_ev)
  );

  step_pacer_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
    .clock (clock),
    .reset (reset),
    .key   (key_mode),
    .press (mode_ev)
  );

  // NOTE: every output of this block gets a default first, so no path
  // through the case statement can leave a value held and infer a latch.
  always_comb begin
    state_next = state;
    presc_next = presc;
    step_next  = 1'b0;
    wrap       = (presc == PW'(TICK_DIV - 1));
    case (state)
      MANUAL: begin
        // A coincident mode press wins and swallows the manual step.
        if (mode_ev) begin
          state_next = AUTO;
          presc_next = '0;
        end else if (step_ev) begin
          step_next = 1'b1;
        end
      end
      AUTO: begin
        presc_next = wrap ? '0 : presc + PW'(1);
        step_next  = wrap;
        if (mode_ev)      state_next = MANUAL;
        else if (step_ev) state_next = HOLD;
      end
      HOLD: begin
        if (mode_ev)      state_next = MANUAL;
        else if (step_ev) state_next = AUTO;
      end
      default: state_next = MANUAL;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= MANUAL;
      presc      <= '0;
      step       <= 1'b0;
      step_count <= '0;
    end else begin
      state      <= state_next;
      presc      <= presc_next;
      step       <= step_next;
      step_count <= step_count + {7'd0, step};
    end
  end

  assign mode = state;
endmodule

// File: tb/tb_step_pacer.sv
// Self-checking bench for step_pacer: directed vector table, hand-written corner
// sequences, and random key activity compared against an event-level model.
module tb_step_pacer;
  localparam int TD = 5;
  localparam int DB = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       key_step = 1'b1;
  logic       key_mode = 1'b1;
  logic       step;
  logic [1:0] mode;
  logic [7:0] step_count;

  always #5 clock = ~clock;

  step_pacer #(.TICK_DIV(TD), .DB_CYCLES(DB)) dut (
    .clock      (clock),
    .reset      (reset),
    .key_step   (key_step),
    .key_mode   (key_mode),
    .step       (step),
    .mode       (mode),
    .step_count (step_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model: a key press is accepted once the raw samples taken two
  // to DB+1 edges ago all disagree with the accepted level; modes and the
  // auto cadence are tracked as plain counts of edges.
  logic [DB+1:0] hist_s, hist_m;
  bit lvl_s, lvl_m, pend_s, pend_m, m_step;
  int m_mode, elapsed, m_count;

  task automatic model_reset();
    hist_s = '1; hist_m = '1;
    lvl_s = 1; lvl_m = 1; pend_s = 0; pend_m = 0;
    m_step = 0; m_mode = 0; elapsed = 0; m_count = 0;
  endtask

  task automatic model_edge(input bit ks, input bit km);
    bit new_step;
    bit all_lo_s, all_hi_s, all_lo_m, all_hi_m;
    m_count = (m_count + int'(m_step)) % 256;
    new_step = 0;
    case (m_mode)
      0: begin
        if (pend_m) begin m_mode = 1; elapsed = 0; end
        else if (pend_s) new_step = 1;
      end
      1: begin
        elapsed++;
        new_step = (elapsed % TD == 0);
        if (pend_m) m_mode = 0;
        else if (pend_s) m_mode = 2;
      end
      default: begin
        if (pend_m) m_mode = 0;
        else if (pend_s) m_mode = 1;
      end
    endcase
    m_step = new_step;
    hist_s = {hist_s[DB:0], ks};
    hist_m = {hist_m[DB:0], km};
    all_lo_s = (hist_s[DB+1:2] == '0); all_hi_s = (hist_s[DB+1:2] == '1);
    all_lo_m = (hist_m[DB+1:2] == '0); all_hi_m = (hist_m[DB+1:2] == '1);
    pend_s = 0; pend_m = 0;
    if (lvl_s && all_lo_s) begin lvl_s = 0; pend_s = 1; end
    else if (!lvl_s && all_hi_s) lvl_s = 1;
    if (lvl_m && all_lo_m) begin lvl_m = 0; pend_m = 1; end
    else if (!lvl_m && all_hi_m) lvl_m = 1;
  endtask

  task automatic tick();
    bit ks, km;
    ks = key_step;
    km = key_mode;
    @(posedge clock);
    model_edge(ks, km);
    #1;
    check("cyc_step", step, m_step);
    check("cyc_mode", mode, m_mode);
    check("cyc_count", step_count, m_count);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_step", step, 0);
    check("rst_mode", mode, 0);
    check("rst_count", step_count, 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic press_until(input bit use_step, input bit use_mode, input int target, input string name);
    int n;
    n = 0;
    key_step = use_step ? 1'b0 : 1'b1;
    key_mode = use_mode ? 1'b0 : 1'b1;
    while (mode != 2'(target) && n < 20) begin tick(); n++; end
    check(name, mode, target);
    key_step = 1'b1;
    key_mode = 1'b1;
  endtask

  typedef struct {
    bit ks;
    bit km;
    int cycles;
    int exp_mode;
    int exp_count;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got 0, expected 1");
    $fatal(1);
  end

  initial begin
    vec_t vecs[8];
    int   hi, first, n, rem, c0;
    int   hits[$];

    vecs[0] = '{0, 1, 3,  0, 1};  // 3-cycle glitch
    vecs[1] = '{1, 1, 10, 0, 1};
    vecs[2] = '{0, 1, 2,  0, 1};  // 2-cycle glitch
    vecs[3] = '{1, 1, 10, 0, 1};
    vecs[4] = '{0, 1, 6,  0, 1};  // accepted, step lands in the next row
    vecs[5] = '{1, 1, 10, 0, 2};
    vecs[6] = '{1, 0, 10, 1, 2};  // enter AUTO at row edge 7
    vecs[7] = '{1, 1, 10, 1, 4};  // wraps at edges 12 and 17 after entry

    model_reset();
    do_reset();

    hi = 0;
    repeat (20) begin tick(); if (step) hi++; end
    check("idle_steps", hi, 0);
    check("idle_mode", mode, 0);
    check("idle_count", step_count, 0);

    key_step = 1'b0;
    first = -1; hi = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (step) begin hi++; if (first < 0) first = k; end
    end
    check("press_latency", first, DB + 3);
    check("press_steps", hi, 1);
    key_step = 1'b1;
    repeat (10) tick();
    check("release_count", step_count, 1);

    for (int i = 0; i < 8; i++) begin
      key_step = vecs[i].ks;
      key_mode = vecs[i].km;
      repeat (vecs[i].cycles) tick();
      check($sformatf("vec%0d_mode", i), mode, vecs[i].exp_mode);
      check($sformatf("vec%0d_count", i), step_count, vecs[i].exp_count);
    end
    key_step = 1'b1; key_mode = 1'b1;

    // Pause in AUTO, stay silent, then resume from the frozen count.
    press_until(1, 0, 2, "hold_enter");
    hi = 0;
    repeat (30) begin tick(); if (step) hi++; end
    check("hold_steps", hi, 0);
    check("hold_mode", mode, 2);
    press_until(1, 0, 1, "hold_resume");
    rem = TD - (elapsed % TD);
    n = 1;
    tick();
    while (!step && n < 20) begin tick(); n++; end
    check("resume_latency", n, rem);

    // Auto cadence measured from mode entry.
    press_until(0, 1, 0, "to_manual");
    repeat (10) tick();
    c0 = step_count;
    press_until(0, 1, 1, "enter_auto");
    for (int k = 1; k <= 22; k++) begin tick(); if (step) hits.push_back(k); end
    check("auto_nsteps", hits.size(), 4);
    for (int i = 0; i < hits.size() && i < 4; i++)
      check($sformatf("auto_step%0d_time", i), hits[i], TD * (i + 1));
    check("auto_count_delta", 8'(step_count - 8'(c0)), 4);

    // Coincident presses in MANUAL: mode wins, no step.
    press_until(0, 1, 0, "back_manual");
    repeat (10) tick();
    c0 = step_count;
    key_step = 1'b0; key_mode = 1'b0;
    hi = 0;
    repeat (10) begin tick(); if (step) hi++; end
    check("simul_mode", mode, 1);
    check("simul_steps", hi, 0);
    check("simul_count", step_count, c0);
    key_step = 1'b1; key_mode = 1'b1;

    // Reset while a step is high; key_step is then held through release.
    n = 0;
    while (!step && n < 20) begin tick(); n++; end
    check("auto_step_seen", step, 1);
    key_step = 1'b0;
    reset = 1'b1;
    #1;
    check("abort_step", step, 0);
    check("abort_mode", mode, 0);
    check("abort_count", step_count, 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    first = -1; hi = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (step) begin hi++; if (first < 0) first = k; end
    end
    check("held_latency", first, DB + 3);
    check("held_steps", hi, 1);
    key_step = 1'b1;
    repeat (10) tick();

    // step_count wrap.
    press_until(0, 1, 1, "wrap_auto");
    n = 0;
    while (step_count != 8'd255 && n < 2000) begin tick(); n++; end
    check("reach_255", step_count, 255);
    n = 0;
    while (step_count == 8'd255 && n < 10) begin tick(); n++; end
    check("wrap_zero", step_count, 0);

    // Random key activity with occasional resets.
    for (int s = 0; s < 250; s++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      key_step = ($urandom_range(0, 2) != 0);
      key_mode = ($urandom_range(0, 4) != 0);
      repeat ($urandom_range(1, 12)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/step_pacer.md
STEP_PACER -- requirements
Module: step_pacer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000, meaning clock cycles between auto-steps (legal range 2 to 2^26).
REQ-002 SHALL have parameter DB_CYCLES, default 1000000, meaning consecutive stable cycles needed to accept a button change (legal range 2 to 2^20).
REQ-003 SHALL have port clock  input  1  single system clock; all state changes occur on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port key_step  input  1  raw active-low pushbutton (0 = pressed) used for the manual step and for pause/resume.
REQ-006 SHALL have port key_mode  input  1  raw active-low pushbutton that toggles between manual and automatic operation.
REQ-007 SHALL have port step  output  1  one-cycle advance strobe to the downstream state register's clock enable.
REQ-008 SHALL have port mode  output  2  current mode: 00 MANUAL, 01 AUTO, 10 HOLD (11 never driven).
REQ-009 SHALL have port step_count  output  8  number of step strobes issued since reset, modulo 256.

Function
REQ-010 SHALL register each raw key through a 2-flop synchronizer whose flops reset to 1 (released).
REQ-011 SHALL run one debounce counter per key: it increments while the synchronized value differs from the debounced level and clears to 0 when they match.
REQ-012 SHALL flip the debounced level on the edge where the counter would reach DB_CYCLES, then clear the counter.
REQ-013 SHALL generate a one-cycle press event only on a debounced 1->0 transition; a debounced release generates no event.
REQ-014 SHALL deliver the manual step with fixed latency: step is high exactly during the cycle after edge DB_CYCLES+3, counting the first edge that samples the pressed raw level as edge 1.
REQ-015 SHALL ignore glitches shorter than DB_CYCLES cycles: such a glitch produces no event and no step.
REQ-016 SHALL, in MANUAL, issue one step per key_step press event.
REQ-017 SHALL, in MANUAL, go to AUTO on a key_mode press and clear the prescaler to 0.
REQ-018 SHALL, in AUTO, count the prescaler 0..TICK_DIV-1; the wrap from TICK_DIV-1 to 0 issues step in the following cycle.
REQ-019 SHALL make the first AUTO step occur TICK_DIV cycles after entering AUTO, with later steps exactly TICK_DIV cycles apart.
REQ-020 SHALL, in AUTO, go to HOLD on a key_step press; a wrap in that same cycle still issues its step.
REQ-021 SHALL, in AUTO, go to MANUAL on a key_mode press.
REQ-022 SHALL, in HOLD, freeze the prescaler and issue no steps.
REQ-023 SHALL, in HOLD, return to AUTO on a key_step press and resume the prescaler from its frozen value.
REQ-024 SHALL, in HOLD, go to MANUAL on a key_mode press.
REQ-025 SHALL, when key_step and key_mode press events coincide, let key_mode win and discard key_step, so no manual step is issued.
REQ-026 SHALL keep step high for exactly one cycle per event, never asserted on two consecutive cycles from a single cause.
REQ-027 SHALL increment step_count on every cycle step is high, wrapping from 255 to 0 with no flag.
REQ-028 SHALL drive step, mode and step_count directly from flops.

Reset
REQ-029 SHALL, while reset is high, force immediately without waiting for a clock edge: step=0, mode=00, step_count=0, prescaler=0, debounce counters=0, debounced levels=1, synchronizers=1.
REQ-030 SHALL abort a step in flight on reset mid-operation (step drops asynchronously) and SHALL NOT issue that step after reset release.
REQ-031 SHALL treat a key held low through reset release as a new press, producing one event DB_CYCLES+3 edges after release.

Verification (TICK_DIV=5, DB_CYCLES=4)
REQ-032 SHALL check: reset pulse, then idle 20 cycles -> step never high, mode=00, step_count=0.
REQ-033 SHALL check: key_step low for 10 cycles in MANUAL -> step high only in the cycle after edge 7; step_count=1; the release adds nothing.
REQ-034 SHALL check: key_step low for 3 cycles -> no step; step_count unchanged.
REQ-035 SHALL check: key_mode press, then 22 cycles after mode=01 -> steps at mode-entry+5, +10, +15, +20; step_count=4.
REQ-036 SHALL check: in AUTO, press key_step -> mode=10 with no steps for 30 cycles; press again -> mode=01 and the next step arrives after the remaining prescaler count.
REQ-037 SHALL check: simultaneous presses in MANUAL -> mode=01 and no step; reset asserted mid-AUTO -> all outputs reset within the same cycle; step_count wraps 255->0 after 256 steps.
